// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
//
// AXI4 slave endpoint backed by an on-chip simple-dual-port RAM. Serves as a
// DDR stand-in on bring-up builds and as a memory-port responder in sims.
// The write channel (AW/W/B) and the read channel (AR/R) are independent
// state machines. They share the RAM through its separate write and read
// ports, so neither channel ever stalls the other.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   s_axi_aw*           write address channel (lock/cache/prot/qos ignored)
//   s_axi_w*            write data channel, byte enables via wstrb
//   s_axi_b*            write response channel
//   s_axi_ar*           read address channel (lock/cache/prot/qos ignored)
//   s_axi_r*            read data channel
// ---------------------------------------------------------------------------
module axi_mem_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                ID_W       = 8,
    parameter int                DATA_W     = 64,
    parameter int                DEPTH_LOG2 = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int         STRB_W    = DATA_W / 8;
    localparam int         OFF_W     = $clog2(STRB_W);
    localparam int         SPAN_LOG2 = DEPTH_LOG2 + OFF_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Sideband attributes have no meaning for a flat RAM.
    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> SPAN_LOG2) == '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return DEPTH_LOG2'((addr - BASE_ADDR) >> OFF_W);
    endfunction

    // Encodings are ordered so that the numerically larger code is the more
    // severe one (DECERR > SLVERR > OKAY), which makes accumulation a max.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // WRAP and the reserved burst type are addressed like INCR but flagged.
    function automatic logic [1:0] beat_err(input logic [ADDR_W-1:0] addr,
                                            input logic [1:0]        burst);
        logic [1:0] e;
        e = burst[1] ? RESP_SLVERR : RESP_OKAY;
        if (!addr_in_range(addr)) e = RESP_DECERR;
        return e;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        return (burst == BURST_FIXED) ? addr : addr + (ADDR_W'(1) << size);
    endfunction

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d, bresp_q, bresp_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              mem_we, w_beat_last;
    logic [1:0]        w_beat_resp;

    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, rd_beat_addr;
    logic [7:0]        ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d, rresp_q, rresp_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_en;

    // The burst ends on the beat count; wlast disagreeing with the count is
    // reported rather than used to cut the burst short.
    assign w_beat_last = (w_cnt_q == aw_len_q);
    assign w_beat_resp = (s_axi_wlast != w_beat_last)
                         ? worse(beat_err(aw_addr_q, aw_burst_q), RESP_SLVERR)
                         : beat_err(aw_addr_q, aw_burst_q);

    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid && awready_q) begin
                aw_addr_d  = s_axi_awaddr;
                aw_len_d   = s_axi_awlen;
                aw_size_d  = s_axi_awsize;
                aw_burst_d = s_axi_awburst;
                bid_d      = s_axi_awid;
                bresp_d    = RESP_OKAY;
                w_cnt_d    = '0;
                awready_d  = 1'b0;
                wready_d   = 1'b1;
                w_state_d  = W_DATA;
            end
            W_DATA: if (s_axi_wvalid && wready_q) begin
                mem_we    = addr_in_range(aw_addr_q);
                bresp_d   = worse(bresp_q, w_beat_resp);
                aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
                w_cnt_d   = w_cnt_q + 8'd1;
                if (w_beat_last) begin
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready && bvalid_q) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Each accepted beat issues the RAM read for the following beat, so the
    // RAM output register always holds the beat currently on the R channel.
    always_comb begin
        r_state_d    = r_state_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        ar_size_d    = ar_size_q;
        ar_burst_d   = ar_burst_q;
        r_cnt_d      = r_cnt_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rresp_d      = rresp_q;
        rid_d        = rid_q;
        rd_en        = 1'b0;
        rd_beat_addr = ar_addr_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid && arready_q) begin
                rd_en        = 1'b1;
                rd_beat_addr = s_axi_araddr;
                ar_addr_d    = next_addr(s_axi_araddr, s_axi_arsize, s_axi_arburst);
                ar_len_d     = s_axi_arlen;
                ar_size_d    = s_axi_arsize;
                ar_burst_d   = s_axi_arburst;
                r_cnt_d      = '0;
                rid_d        = s_axi_arid;
                rlast_d      = (s_axi_arlen == 8'd0);
                rresp_d      = beat_err(s_axi_araddr, s_axi_arburst);
                rvalid_d     = 1'b1;
                arready_d    = 1'b0;
                r_state_d    = R_DATA;
            end
            R_DATA: if (s_axi_rready && rvalid_q) begin
                if (rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    rd_en     = 1'b1;
                    ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
                    r_cnt_d   = r_cnt_q + 8'd1;
                    rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                    rresp_d   = beat_err(ar_addr_q, ar_burst_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= '0;
            rid_q      <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rid_q      <= rid_d;
        end
    end

    // RAM write port: contents are never reset, and nothing is written
    // while reset is asserted.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[word_idx(aw_addr_q)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // RAM read port: nonblocking read gives read-first behaviour on a same-word
    // collision; out-of-range beats return zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= addr_in_range(rd_beat_addr) ? mem[word_idx(rd_beat_addr)] : '0;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_responder
//
// Self-checking bench for axi_mem_responder. A byte-level reference memory
// (associative array of words) tracks every write; read beats and write
// responses are predicted from the address/burst rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;

   localparam longint BASE = 64'h4000_0000;
   localparam longint SPAN = 64'h2_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [7:0]  s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [7:0]  s_axi_arid = '0;
   logic [31:0] s_axi_araddr = '0;
   logic [7:0]  s_axi_arlen = '0;
   logic [2:0]  s_axi_arsize = '0;
   logic [1:0]  s_axi_arburst = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [7:0]  s_axi_rid;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;

   int errCount = 0;
   int checkCount = 0;

   logic [63:0] refMem [int];
   logic [63:0] wq [$];
   logic [7:0]  sq [$];
   logic [63:0] rdQ [$];
   logic [1:0]  rrQ [$];
   logic        rlQ [$];
   logic [7:0]  riQ [$];

   axi_mem_responder dut (
      .clock(clock), .reset(reset),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
      .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
      .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Hard stop in case some bounded wait was missed.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expVal);
      checkCount++;
      if (got !== expVal) begin
         errCount++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, expVal);
      end
   endtask

   // Reference model: address of beat i, range test, severity ordering.
   function automatic longint beatAddrOf(longint a, int i, int sz, logic [1:0] burst);
      return (burst == 2'b00) ? a : a + longint'(i) * (longint'(1) << sz);
   endfunction

   function automatic bit inRange(longint a);
      return (a >= BASE) && (a < BASE + SPAN);
   endfunction

   function automatic logic [1:0] worse(logic [1:0] a, logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [63:0] expData(longint a);
      int k;
      if (!inRange(a)) return 64'd0;
      k = int'((a - BASE) / 8);
      return refMem.exists(k) ? refMem[k] : 64'd0;
   endfunction

   function automatic logic [1:0] expResp(longint a, logic [1:0] burst);
      logic [1:0] r;
      r = burst[1] ? 2'b10 : 2'b00;
      if (!inRange(a)) r = 2'b11;
      return r;
   endfunction

   // Applies the beats in wq/sq to the reference memory, returns expected bresp.
   function automatic logic [1:0] modelWrite(longint addr, int len, int sz, logic [1:0] burst, int wlastBeat);
      logic [1:0]  r;
      logic [63:0] w;
      longint      a;
      int          k;
      r = 2'b00;
      for (int i = 0; i <= len; i++) begin
         a = beatAddrOf(addr, i, sz, burst);
         if (burst[1]) r = worse(r, 2'b10);
         if ((i == wlastBeat) != (i == len)) r = worse(r, 2'b10);
         if (inRange(a)) begin
            k = int'((a - BASE) / 8);
            w = refMem.exists(k) ? refMem[k] : 64'd0;
            for (int b = 0; b < 8; b++) if (sq[i][b]) w[b*8 +: 8] = wq[i][b*8 +: 8];
            refMem[k] = w;
         end else begin
            r = 2'b11;
         end
      end
      return r;
   endfunction

   task automatic axiWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id, input int wlastBeat,
                           input bit stall, output logic [1:0] resp, output logic [7:0] bidOut,
                           output int beats);
      int cyc;
      bit hs;
      bit got;
      resp = 2'bxx;
      bidOut = 8'hxx;
      beats = 0;
      s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
      s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < 50) begin @(posedge clock); #1; cyc++; end
      if (!s_axi_awready) begin
         checkOutput("aw_timeout", 64'd0, 64'd1);
         s_axi_awvalid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      s_axi_awvalid = 1'b0;
      cyc = 0;
      while (beats <= int'(len) && cyc < 300) begin
         s_axi_wvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axi_wdata  = wq[beats];
         s_axi_wstrb  = sq[beats];
         s_axi_wlast  = (beats == wlastBeat);
         hs = s_axi_wvalid && s_axi_wready;
         @(posedge clock); #1; cyc++;
         if (hs) beats++;
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 100) begin
         s_axi_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (s_axi_bvalid && s_axi_bready) begin
            resp = s_axi_bresp;
            bidOut = s_axi_bid;
            got = 1'b1;
         end
         @(posedge clock); #1; cyc++;
      end
      s_axi_bready = 1'b0;
      if (!got) checkOutput("b_timeout", 64'd0, 64'd1);
   endtask

   // mode 0: rready always high, 1: pattern 1,0,0 repeating, 2: random.
   task automatic axiRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] id, input int mode,
                          output int beats);
      int          cyc;
      bit          done;
      bit          held;
      logic [63:0] hd;
      logic [1:0]  hr;
      logic        hl;
      logic [7:0]  hi;
      rdQ.delete(); rrQ.delete(); rlQ.delete(); riQ.delete();
      beats = 0;
      s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
      s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
      cyc = 0;
      while (!s_axi_arready && cyc < 50) begin @(posedge clock); #1; cyc++; end
      if (!s_axi_arready) begin
         checkOutput("ar_timeout", 64'd0, 64'd1);
         s_axi_arvalid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      s_axi_arvalid = 1'b0;
      checkOutput("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
      cyc = 0; done = 1'b0; held = 1'b0;
      hd = '0; hr = '0; hl = 1'b0; hi = '0;
      while (!done && cyc < 200) begin
         case (mode)
            0: s_axi_rready = 1'b1;
            1: s_axi_rready = (cyc % 3 == 0);
            default: s_axi_rready = 1'($urandom_range(0, 1));
         endcase
         if (held) begin
            checkOutput("hold_valid", 64'(s_axi_rvalid), 64'd1);
            checkOutput("hold_data", s_axi_rdata, hd);
            checkOutput("hold_resp", 64'(s_axi_rresp), 64'(hr));
            checkOutput("hold_last", 64'(s_axi_rlast), 64'(hl));
            checkOutput("hold_id", 64'(s_axi_rid), 64'(hi));
         end
         held = 1'b0;
         if (s_axi_rvalid && s_axi_rready) begin
            rdQ.push_back(s_axi_rdata); rrQ.push_back(s_axi_rresp);
            rlQ.push_back(s_axi_rlast); riQ.push_back(s_axi_rid);
            beats++;
            done = s_axi_rlast || (beats > int'(len) + 1);
         end else if (s_axi_rvalid) begin
            held = 1'b1;
            hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast; hi = s_axi_rid;
         end
         @(posedge clock); #1; cyc++;
      end
      s_axi_rready = 1'b0;
      if (!done) checkOutput("r_timeout", 64'd0, 64'd1);
      checkOutput("rvalid_drop", 64'(s_axi_rvalid), 64'd0);
      checkOutput("arready_back", 64'(s_axi_arready), 64'd1);
   endtask

   task automatic checkRead(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] id,
                            input int beats);
      longint a;
      checkOutput({tag, "_beats"}, 64'(beats), 64'(len) + 64'd1);
      for (int i = 0; i < beats && i <= int'(len); i++) begin
         a = beatAddrOf(longint'(addr), i, int'(size), burst);
         checkOutput({tag, "_data"}, rdQ[i], expData(a));
         checkOutput({tag, "_resp"}, 64'(rrQ[i]), 64'(expResp(a, burst)));
         checkOutput({tag, "_last"}, 64'(rlQ[i]), 64'(i == int'(len)));
         checkOutput({tag, "_id"}, 64'(riQ[i]), 64'(id));
      end
   endtask

   // One randomized iteration: full-strobe write, random-strobe overwrite,
   // then a read-back with random backpressure.
   task automatic applyStimulus();
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [7:0]  id;
      logic [7:0]  bidOut;
      logic [1:0]  resp;
      logic [1:0]  expR;
      int          beats;
      addr = 32'h4000_1000 + 32'($urandom_range(0, 4000)) * 32'd8;
      len  = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd2;
      id   = 8'($urandom);
      for (int pass = 0; pass < 2; pass++) begin
         wq.delete(); sq.delete();
         for (int i = 0; i <= int'(len); i++) begin
            wq.push_back({$urandom, $urandom});
            sq.push_back(pass == 0 ? 8'hFF : 8'($urandom));
         end
         expR = modelWrite(longint'(addr), int'(len), int'(size), 2'b01, int'(len));
         axiWrite(addr, len, size, 2'b01, id, int'(len), 1'b1, resp, bidOut, beats);
         checkOutput("rnd_bresp", 64'(resp), 64'(expR));
         checkOutput("rnd_bid", 64'(bidOut), 64'(id));
         checkOutput("rnd_wbeats", 64'(beats), 64'(len) + 64'd1);
      end
      axiRead(addr, len, size, 2'b01, ~id, 2, beats);
      checkRead("rnd", addr, len, size, 2'b01, ~id, beats);
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [1:0] resp;
      logic [1:0] expR;
      logic [7:0] bidOut;
      int         beats;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("rst_awready", 64'(s_axi_awready), 64'd1);
      checkOutput("rst_arready", 64'(s_axi_arready), 64'd1);
      checkOutput("rst_wready", 64'(s_axi_wready), 64'd0);
      checkOutput("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      checkOutput("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      checkOutput("rst_rlast", 64'(s_axi_rlast), 64'd0);
      checkOutput("rst_bresp", 64'(s_axi_bresp), 64'd0);
      checkOutput("rst_rresp", 64'(s_axi_rresp), 64'd0);
      checkOutput("rst_bid", 64'(s_axi_bid), 64'd0);
      checkOutput("rst_rid", 64'(s_axi_rid), 64'd0);
      checkOutput("rst_rdata", s_axi_rdata, 64'd0);

      $display("[TB] write then read");
      wq = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      expR = modelWrite(BASE, 3, 3, 2'b01, 3);
      axiWrite(32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'hA5, 3, 1'b0, resp, bidOut, beats);
      checkOutput("wr_bresp", 64'(resp), 64'd0);
      checkOutput("wr_bid", 64'(bidOut), 64'hA5);
      checkOutput("wr_awready_after_b", 64'(s_axi_awready), 64'd1);
      axiRead(32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'h3C, 0, beats);
      checkRead("rd", 32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'h3C, beats);
      if (beats == 4) checkOutput("rd_beat3", rdQ[3], 64'h4444_4444_4444_4444);

      $display("[TB] byte strobe");
      wq = '{64'hFFFF_FFFF_FFFF_FFFF}; sq = '{8'hFF};
      expR = modelWrite(BASE + 64'h100, 0, 3, 2'b01, 0);
      axiWrite(32'h4000_0100, 8'd0, 3'd3, 2'b01, 8'h01, 0, 1'b0, resp, bidOut, beats);
      wq = '{64'h0}; sq = '{8'h0F};
      expR = modelWrite(BASE + 64'h100, 0, 3, 2'b01, 0);
      axiWrite(32'h4000_0100, 8'd0, 3'd3, 2'b01, 8'h02, 0, 1'b0, resp, bidOut, beats);
      checkOutput("strb_bresp", 64'(resp), 64'(expR));
      axiRead(32'h4000_0100, 8'd0, 3'd3, 2'b01, 8'h03, 0, beats);
      checkRead("strb", 32'h4000_0100, 8'd0, 3'd3, 2'b01, 8'h03, beats);
      if (beats >= 1) checkOutput("strb_value", rdQ[0], 64'hFFFF_FFFF_0000_0000);

      $display("[TB] backpressure");
      wq.delete(); sq.delete();
      for (int i = 0; i < 8; i++) begin wq.push_back({$urandom, $urandom}); sq.push_back(8'hFF); end
      expR = modelWrite(BASE + 64'h200, 7, 3, 2'b01, 7);
      axiWrite(32'h4000_0200, 8'd7, 3'd3, 2'b01, 8'h10, 7, 1'b1, resp, bidOut, beats);
      checkOutput("bp_bresp", 64'(resp), 64'(expR));
      axiRead(32'h4000_0200, 8'd7, 3'd3, 2'b01, 8'h77, 1, beats);
      checkRead("bp", 32'h4000_0200, 8'd7, 3'd3, 2'b01, 8'h77, beats);

      $display("[TB] error responses");
      axiRead(32'h4002_0000, 8'd1, 3'd3, 2'b01, 8'h44, 0, beats);
      checkRead("oor_rd", 32'h4002_0000, 8'd1, 3'd3, 2'b01, 8'h44, beats);
      if (beats >= 2) checkOutput("oor_rd_resp1", 64'(rrQ[1]), 64'd3);
      wq = '{64'hDEAD_BEEF_DEAD_BEEF}; sq = '{8'hFF};
      expR = modelWrite(BASE - 64'd8, 0, 3, 2'b01, 0);
      axiWrite(32'h3FFF_FFF8, 8'd0, 3'd3, 2'b01, 8'h45, 0, 1'b0, resp, bidOut, beats);
      checkOutput("oor_wr_bresp", 64'(resp), 64'd3);
      wq = '{64'd1, 64'd2, 64'd3, 64'd4}; sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      expR = modelWrite(BASE + 64'h400, 3, 3, 2'b10, 3);
      axiWrite(32'h4000_0400, 8'd3, 3'd3, 2'b10, 8'h46, 3, 1'b0, resp, bidOut, beats);
      checkOutput("wrap_bresp", 64'(resp), 64'd2);
      expR = modelWrite(BASE + 64'h500, 3, 3, 2'b01, 2);
      axiWrite(32'h4000_0500, 8'd3, 3'd3, 2'b01, 8'h47, 2, 1'b0, resp, bidOut, beats);
      checkOutput("wlast_bresp", 64'(resp), 64'd2);
      checkOutput("wlast_beats", 64'(beats), 64'd4);

      $display("[TB] fixed burst");
      wq = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C};
      sq = '{8'hFF, 8'hFF, 8'hFF};
      expR = modelWrite(BASE + 64'h300, 2, 3, 2'b00, 2);
      axiWrite(32'h4000_0300, 8'd2, 3'd3, 2'b00, 8'h50, 2, 1'b0, resp, bidOut, beats);
      checkOutput("fix_bresp", 64'(resp), 64'd0);
      axiRead(32'h4000_0300, 8'd2, 3'd3, 2'b00, 8'h51, 2, beats);
      checkRead("fix_rd", 32'h4000_0300, 8'd2, 3'd3, 2'b00, 8'h51, beats);
      if (beats == 3) checkOutput("fix_value", rdQ[2], 64'hCCCC_0000_0000_000C);

      $display("[TB] reset mid-read");
      s_axi_araddr = 32'h4000_0000; s_axi_arlen = 8'd7; s_axi_arsize = 3'd3;
      s_axi_arburst = 2'b01; s_axi_arid = 8'h5A; s_axi_arvalid = 1'b1;
      @(posedge clock); #1;
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      checkOutput("mid_rvalid", 64'(s_axi_rvalid), 64'd1);
      checkOutput("mid_rdata", s_axi_rdata, 64'h3333_3333_3333_3333);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      s_axi_rready = 1'b0;
      checkOutput("post_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      checkOutput("post_rst_arready", 64'(s_axi_arready), 64'd1);
      checkOutput("post_rst_rlast", 64'(s_axi_rlast), 64'd0);
      axiRead(32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'h5B, 0, beats);
      checkRead("post_rst", 32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'h5B, beats);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 8; n++) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
